// File: rtl/beep_sequencer.sv
// Piezo buzzer arbiter: plays the fixed note sequence for apple, poison and
// die events. A higher-priority request pre-empts, the same source retriggers.
module beep_sequencer #(
    parameter int unsigned HP_W      = 16,
    parameter int unsigned LEN_W     = 22,
    parameter int unsigned HP_APPLE  = 6250,
    parameter int unsigned HP_POISON = 25000,
    parameter int unsigned HP_DIE1   = 12500,
    parameter int unsigned HP_DIE2   = 17857,
    parameter int unsigned HP_DIE3   = 31250,
    parameter int unsigned NOTE_CYC  = 2500000,
    parameter int unsigned GAP_CYC   = 1250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_apple,
    input  logic       req_poison,
    input  logic       req_die,
    input  logic       mute,
    output logic       beep,
    output logic       busy,
    output logic [1:0] active_id,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [HP_W-1:0]  HP_APPLE_LAST  = HP_W'(HP_APPLE - 1);
    localparam logic [HP_W-1:0]  HP_POISON_LAST = HP_W'(HP_POISON - 1);
    localparam logic [HP_W-1:0]  HP_DIE1_LAST   = HP_W'(HP_DIE1 - 1);
    localparam logic [HP_W-1:0]  HP_DIE2_LAST   = HP_W'(HP_DIE2 - 1);
    localparam logic [HP_W-1:0]  HP_DIE3_LAST   = HP_W'(HP_DIE3 - 1);
    localparam logic [LEN_W-1:0] NOTE_LAST      = LEN_W'(NOTE_CYC - 1);
    localparam logic [LEN_W-1:0] GAP_LAST       = LEN_W'(GAP_CYC - 1);

    state_t            state, state_nxt;
    logic [1:0]        id, id_nxt;
    logic [1:0]        note_idx, idx_nxt;
    logic [HP_W-1:0]   hc, hc_nxt;
    logic [LEN_W-1:0]  nc, nc_nxt;
    logic              tone, tone_nxt;
    logic              beep_nxt;
    logic              done_nxt;

    logic [1:0]        winner;
    logic              accept;
    logic [HP_W-1:0]   hp_last;
    logic              last_note;

    always_comb begin
        winner = 2'd0;
        if (req_die)
            winner = 2'd3;
        else if (req_poison)
            winner = 2'd2;
        else if (req_apple)
            winner = 2'd1;
    end

    // id is 0 in IDLE, so ">=" also covers retrigger of the playing source
    assign accept = (winner != 2'd0) && ((state == IDLE) || (winner >= id));

    always_comb begin
        hp_last = HP_APPLE_LAST;
        case (id)
            2'd2: hp_last = HP_POISON_LAST;
            2'd3: begin
                case (note_idx)
                    2'd0:    hp_last = HP_DIE1_LAST;
                    2'd1:    hp_last = HP_DIE2_LAST;
                    default: hp_last = HP_DIE3_LAST;
                endcase
            end
            default: hp_last = HP_APPLE_LAST;
        endcase
    end

    // Apple has 1 note, poison 2, die 3: the last index is always id-1
    assign last_note = (note_idx == (id - 2'd1));

    always_comb begin
        state_nxt = state;
        id_nxt    = id;
        idx_nxt   = note_idx;
        hc_nxt    = hc;
        nc_nxt    = nc;
        tone_nxt  = tone;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                hc_nxt   = '0;
                nc_nxt   = '0;
                tone_nxt = 1'b0;
            end
            PLAY: begin
                if (hc == hp_last) begin
                    hc_nxt   = '0;
                    tone_nxt = ~tone;
                end else begin
                    hc_nxt = hc + 1'b1;
                end
                if (nc == NOTE_LAST) begin
                    nc_nxt   = '0;
                    hc_nxt   = '0;
                    tone_nxt = 1'b0;
                    if (last_note) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                        id_nxt    = 2'd0;
                        idx_nxt   = 2'd0;
                    end else begin
                        state_nxt = GAP;
                    end
                end else begin
                    nc_nxt = nc + 1'b1;
                end
            end
            GAP: begin
                hc_nxt   = '0;
                tone_nxt = 1'b0;
                if (nc == GAP_LAST) begin
                    state_nxt = PLAY;
                    idx_nxt   = note_idx + 2'd1;
                    nc_nxt    = '0;
                end else begin
                    nc_nxt = nc + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                id_nxt    = 2'd0;
                idx_nxt   = 2'd0;
                hc_nxt    = '0;
                nc_nxt    = '0;
                tone_nxt  = 1'b0;
            end
        endcase

        // A new request overrides everything above, including a completion
        if (accept) begin
            state_nxt = PLAY;
            id_nxt    = winner;
            idx_nxt   = 2'd0;
            hc_nxt    = '0;
            nc_nxt    = '0;
            tone_nxt  = 1'b0;
            done_nxt  = 1'b0;
        end

        beep_nxt = tone_nxt & ~mute & (state_nxt == PLAY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            id       <= '0;
            note_idx <= '0;
            hc       <= '0;
            nc       <= '0;
            tone     <= 1'b0;
            beep     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            id       <= id_nxt;
            note_idx <= idx_nxt;
            hc       <= hc_nxt;
            nc       <= nc_nxt;
            tone     <= tone_nxt;
            beep     <= beep_nxt;
            done     <= done_nxt;
        end
    end

    assign busy      = (state != IDLE);
    assign active_id = id;

endmodule
